lfsr_noise_checker: RTL and testbench
=====================================

// Module: lfsr_noise_checker
// PURPOSE
//  Receive-side checker for the 4-bit LFSR noise source (x^4+x^3+1, period 15).
//  - Input samples are lfsr_state*gain (8-bit); the block recovers the LFSR phase from them.
//  - Locks, flywheels the predicted sequence and counts sample errors.
//  - Sits after the noise path in the audio test chain to prove the generator and link are intact.
// PARAMETERS
//  LOCK_COUNT  4   consecutive matches in VERIFY required to declare lock (1..15)
//  LOSS_COUNT  3   consecutive mismatches in LOCKED that drop lock (1..15)
//  CNT_W       16  width of error/sample counters
// PORTS
//  clk           in   1      system clock
//  rst           in   1      asynchronous, active-high reset
//  sample_valid  in   1      one-cycle strobe: noise_in holds a new sample
//  noise_in      in   8      received noise sample
//  noise_gain    in   4      gain the generator is using (1..15), sampled with sample_valid
//  clear         in   1      synchronous clear of err_count and sample_count
//  locked        out  1      high while FSM is in LOCKED
//  err_pulse     out  1      one-cycle pulse on each mismatching sample while LOCKED
//  expected_out  out  8      predicted sample for the current sample (registered)
//  err_count     out  CNT_W  saturating count of mismatches while LOCKED
//  sample_count  out  CNT_W  saturating count of samples checked while LOCKED
// BEHAVIOUR
//  - Reset (async, immediate, also mid-operation):
//    - FSM=SEARCH, pred_state=0, match_cnt=0, bad_run=0.
//    - All outputs 0.
//  - next(s) = {s[2:0], s[3]^s[2]}. Sequence from 2: 2,4,9,3,6,13,10,5,11,7,15,14,12,8,1,2.
//  - All processing happens only on clk edges with sample_valid=1; otherwise state holds.
//  - All outputs are registered: update 1 clk after the qualifying strobe.
//  - SEARCH:
//    - Find s in 1..15 with s*noise_gain == noise_in (full 8-bit compare; unique for gain>=1).
//    - Found: pred_state<=next(s), match_cnt<=0, go VERIFY.
//    - Not found, or noise_gain==0: stay in SEARCH.
//  - VERIFY:
//    - expected = pred_state*noise_gain.
//    - Match: match_cnt+1, pred_state advances.
//      When match_cnt reaches LOCK_COUNT, go LOCKED and set bad_run=0.
//    - Mismatch: go SEARCH. That sample is not re-used for seeding.
//  - LOCKED (flywheel):
//    - pred_state advances on every valid sample, match or not.
//    - sample_count+1 on every valid sample.
//    - Match: bad_run<=0.
//    - Mismatch: err_pulse=1, err_count+1, bad_run+1.
//      When bad_run reaches LOSS_COUNT, go SEARCH; locked drops on the same update.
//  - expected_out holds pred_state*noise_gain computed for the latest valid sample.
//    It is 0 while in SEARCH.
//  - Product width: 4x4 -> 8 bits, max 225, no truncation.
//  - Counters saturate at all-ones and never wrap.
//  - clear:
//    - Same cycle as a counted event: clear wins, counter = 0.
//    - Does not affect FSM, locked or pred_state.
//  - noise_gain change while LOCKED: mismatches are counted normally.
//    Lock is lost after LOSS_COUNT bad samples.
// TESTING
//  1. gain=3, samples 6,12,27,9,18 -> locked=1 one clk after 5th strobe; err_count=0.
//  2. Locked as in 1, then one corrupt sample (0x00 instead of 39):
//     - err_pulse one clk, err_count=1, locked stays 1.
//     - Next sample 30 (10*3) matches, proving flywheel phase is kept.
//  3. Locked, 3 consecutive corrupt samples -> locked=0 after 3rd.
//     Correct stream re-locks after 1+LOCK_COUNT samples.
//  4. gain=0 or noise_in=0x01 with gain=2 in SEARCH -> stays SEARCH, all outputs 0.
//  5. Assert rst mid-VERIFY and mid-LOCKED -> outputs 0 immediately, no clk needed.
//     Assert clear together with an error -> err_count=0.
//  6. Force err_count to all-ones, then more errors -> holds all-ones.
//     Run 15+ samples at gain=15 (max 225) with no mismatch.

Source files
------------

// File: rtl/lfsr_noise_checker_if.sv
// Sample/status bundle between the noise receive path and the LFSR checker.
// master drives samples/gain/clear and observes status; slave is the checker.
interface lfsr_noise_checker_if #(
  parameter int CNT_W = 16
);
  logic             sample_valid;
  logic [7:0]       noise_in;
  logic [3:0]       noise_gain;
  logic             clear;
  logic             locked;
  logic             err_pulse;
  logic [7:0]       expected_out;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] sample_count;

  modport master (
    output sample_valid, noise_in, noise_gain, clear,
    input  locked, err_pulse, expected_out, err_count, sample_count
  );

  modport slave (
    input  sample_valid, noise_in, noise_gain, clear,
    output locked, err_pulse, expected_out, err_count, sample_count
  );
endinterface

// File: rtl/lfsr_noise_checker.sv
// Receive-side checker for the x^4+x^3+1 LFSR noise source (samples = state*gain).
// Ports: clk, rst (async high), bus (slave: samples in, lock/error status out).
module lfsr_noise_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input logic                 clk,
  input logic                 rst,
  lfsr_noise_checker_if.slave bus
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [4:0] LOCK_N = 5'(LOCK_COUNT);
  localparam logic [4:0] LOSS_N = 5'(LOSS_COUNT);

  state_t           state, state_n;
  logic [3:0]       pred_state;
  logic [3:0]       match_cnt;
  logic [3:0]       bad_run;
  logic             err_q;
  logic [7:0]       exp_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] smp_cnt_q;

  logic [7:0] gain8;
  logic [7:0] expected;
  logic       match;
  logic       seed_hit;
  logic [3:0] seed;
  logic [4:0] mc_inc;
  logic [4:0] bad_inc;

  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  assign gain8    = {4'd0, bus.noise_gain};
  assign expected = {4'd0, pred_state} * gain8;
  assign match    = (expected == bus.noise_in);
  assign mc_inc   = 5'(match_cnt) + 5'd1;
  assign bad_inc  = 5'(bad_run) + 5'd1;

  // Phase recovery: the unique state whose product equals the sample.
  always_comb begin
    seed_hit = 1'b0;
    seed     = 4'd0;
    for (int i = 1; i < 16; i++) begin
      if (bus.noise_gain != 4'd0 &&
          8'(i) * gain8 == bus.noise_in) begin
        seed_hit = 1'b1;
        seed     = 4'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEARCH;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (bus.sample_valid) begin
      unique case (state)
        SEARCH: if (seed_hit) state_n = VERIFY;
        VERIFY: begin
          if (!match)              state_n = SEARCH;
          else if (mc_inc == LOCK_N) state_n = LOCKED;
        end
        LOCKED: begin
          if (!match && bad_inc == LOSS_N)
            state_n = SEARCH;
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_comb begin
    bus.locked = (state == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_state <= 4'd0;
      match_cnt  <= 4'd0;
      bad_run    <= 4'd0;
      err_q      <= 1'b0;
      exp_q      <= 8'd0;
      err_cnt_q  <= '0;
      smp_cnt_q  <= '0;
    end else begin
      err_q <= 1'b0;
      if (bus.sample_valid) begin
        unique case (state)
          SEARCH: begin
            exp_q <= 8'd0;
            if (seed_hit) begin
              pred_state <= lfsr_next(seed);
              match_cnt  <= 4'd0;
            end
          end
          VERIFY: begin
            exp_q <= expected;
            if (match) begin
              match_cnt  <= mc_inc[3:0];
              pred_state <= lfsr_next(pred_state);
              if (mc_inc == LOCK_N) bad_run <= 4'd0;
            end
          end
          LOCKED: begin
            exp_q      <= expected;
            pred_state <= lfsr_next(pred_state);
            if (smp_cnt_q != '1)
              smp_cnt_q <= smp_cnt_q + CNT_W'(1);
            if (match) begin
              bad_run <= 4'd0;
            end else begin
              err_q   <= 1'b1;
              bad_run <= bad_inc[3:0];
              if (err_cnt_q != '1)
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
          end
          default: exp_q <= 8'd0;
        endcase
      end
      // Clear overrides any increment on the same edge.
      if (bus.clear) begin
        err_cnt_q <= '0;
        smp_cnt_q <= '0;
      end
    end
  end

  assign bus.err_pulse    = err_q;
  assign bus.expected_out = exp_q;
  assign bus.err_count    = err_cnt_q;
  assign bus.sample_count = smp_cnt_q;

endmodule

// File: tb/tb_lfsr_noise_checker.sv
// Testbench for lfsr_noise_checker: directed scenarios plus random stream
// compared against a table-driven model of the LFSR sequence.
module tb_lfsr_noise_checker;

  localparam int CW    = 5;
  localparam int MAXC  = (1 << CW) - 1;
  localparam int LOCK  = 4;
  localparam int LOSS  = 3;

  logic clk;
  logic rst;

  lfsr_noise_checker_if #(.CNT_W(CW)) bus ();

  lfsr_noise_checker #(
    .LOCK_COUNT(LOCK),
    .LOSS_COUNT(LOSS),
    .CNT_W     (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  int seq [15] = '{2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};

  // Model: mode 0=search 1=verify 2=locked, phase index into seq.
  int m_mode, m_p, m_mc, m_bad, m_ec, m_sc, m_err, m_exp;

  function automatic int pos_of(input int s);
    for (int i = 0; i < 15; i++) if (seq[i] == s) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_p = 0; m_mc = 0; m_bad = 0;
    m_ec = 0; m_sc = 0; m_err = 0; m_exp = 0;
  endtask

  task automatic model_step(input bit v, input int n, input int g, input bit c);
    int e;
    m_err = 0;
    if (v) begin
      if (m_mode == 0) begin
        m_exp = 0;
        if (g != 0)
          for (int s = 1; s < 16; s++)
            if (s * g == n) begin
              m_p = (pos_of(s) + 1) % 15; m_mc = 0; m_mode = 1;
            end
      end else if (m_mode == 1) begin
        e = seq[m_p] * g;
        m_exp = e;
        if (n == e) begin
          m_mc++;
          m_p = (m_p + 1) % 15;
          if (m_mc == LOCK) begin m_mode = 2; m_bad = 0; end
        end else m_mode = 0;
      end else begin
        e = seq[m_p] * g;
        m_exp = e;
        m_p = (m_p + 1) % 15;
        if (m_sc < MAXC) m_sc++;
        if (n == e) m_bad = 0;
        else begin
          m_err = 1;
          if (m_ec < MAXC) m_ec++;
          m_bad++;
          if (m_bad == LOSS) m_mode = 0;
        end
      end
    end
    if (c) begin m_ec = 0; m_sc = 0; end
  endtask

  task automatic step(input bit v, input int n, input int g, input bit c);
    bus.sample_valid = v;
    bus.noise_in     = 8'(n);
    bus.noise_gain   = 4'(g);
    bus.clear        = c;
    @(posedge clk);
    #1;
    model_step(v, n, g, c);
    bus.sample_valid = 1'b0;
    bus.clear        = 1'b0;
  endtask

  task automatic do_reset();
    bus.sample_valid = 1'b0;
    bus.noise_in     = 8'd0;
    bus.noise_gain   = 4'd0;
    bus.clear        = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*CW+9:0] outs();
    return {bus.locked, bus.err_pulse, bus.expected_out,
            bus.err_count, bus.sample_count};
  endfunction

  task automatic test_reset();
    bus.sample_valid = 1'b0;
    bus.clear        = 1'b0;
    rst = 1'b1;
    #7;
    n_total++;
    if (outs() !== '0)
      $display("FAIL reset_outputs got=%h want=0", outs());
    else n_pass++;
    rst = 1'b0;
    model_reset();
    step(0, 0, 0, 0);
    n_total++;
    if (outs() !== '0)
      $display("FAIL idle_after_reset got=%h want=0", outs());
    else n_pass++;
  endtask

  task automatic test_lock();
    int smp [5] = '{6, 12, 27, 9, 18};
    do_reset();
    for (int i = 0; i < 4; i++) step(1, smp[i], 3, 0);
    n_total++;
    if (bus.locked !== 1'b0)
      $display("FAIL lock_early got=%b want=0", bus.locked);
    else n_pass++;
    step(1, smp[4], 3, 0);
    n_total++;
    if (bus.locked !== 1'b1)
      $display("FAIL lock_5th got=%b want=1", bus.locked);
    else n_pass++;
    n_total++;
    if (bus.err_count !== CW'(0) || bus.expected_out !== 8'd18)
      $display("FAIL lock_state err=%0d exp=%0d want 0/18",
               bus.err_count, bus.expected_out);
    else n_pass++;
  endtask

  task automatic test_flywheel();
    step(1, 0, 3, 0);
    n_total++;
    if (bus.err_pulse !== 1'b1 || bus.err_count !== CW'(1) || bus.locked !== 1'b1)
      $display("FAIL fly_err pulse=%b cnt=%0d lk=%b want 1/1/1",
               bus.err_pulse, bus.err_count, bus.locked);
    else n_pass++;
    n_total++;
    if (bus.expected_out !== 8'd39)
      $display("FAIL fly_exp39 got=%0d want=39", bus.expected_out);
    else n_pass++;
    step(1, 30, 3, 0);
    n_total++;
    if (bus.err_pulse !== 1'b0 || bus.err_count !== CW'(1) ||
        bus.expected_out !== 8'd30)
      $display("FAIL fly_phase pulse=%b cnt=%0d exp=%0d want 0/1/30",
               bus.err_pulse, bus.err_count, bus.expected_out);
    else n_pass++;
  endtask

  task automatic test_loss_relock();
    int k;
    step(1, 0, 3, 0);
    step(1, 0, 3, 0);
    n_total++;
    if (bus.locked !== 1'b1)
      $display("FAIL loss_2nd got=%b want=1", bus.locked);
    else n_pass++;
    step(1, 0, 3, 0);
    n_total++;
    if (bus.locked !== 1'b0 || bus.err_count !== CW'(4))
      $display("FAIL loss_3rd lk=%b cnt=%0d want 0/4", bus.locked, bus.err_count);
    else n_pass++;
    k = $urandom_range(0, 14);
    for (int i = 0; i < 4; i++) step(1, seq[(k + i) % 15] * 7, 7, 0);
    n_total++;
    if (bus.locked !== 1'b0)
      $display("FAIL relock_early got=%b want=0", bus.locked);
    else n_pass++;
    step(1, seq[(k + 4) % 15] * 7, 7, 0);
    n_total++;
    if (bus.locked !== 1'b1 || bus.expected_out !== 8'(seq[(k + 4) % 15] * 7))
      $display("FAIL relock lk=%b exp=%0d want 1/%0d",
               bus.locked, bus.expected_out, seq[(k + 4) % 15] * 7);
    else n_pass++;
  endtask

  task automatic test_search_reject();
    do_reset();
    step(1, 6, 0, 0);
    n_total++;
    if (outs() !== '0)
      $display("FAIL gain0 got=%h want=0", outs());
    else n_pass++;
    step(1, 1, 2, 0);
    n_total++;
    if (outs() !== '0)
      $display("FAIL odd_sample got=%h want=0", outs());
    else n_pass++;
    for (int i = 1; i < 5; i++) step(1, seq[i] * 2, 2, 0);
    n_total++;
    if (bus.locked !== 1'b0)
      $display("FAIL reject_no_seed got=%b want=0", bus.locked);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1, 10, 5, 0);
    step(1, 20, 5, 0);
    n_total++;
    if (bus.expected_out !== 8'd20)
      $display("FAIL verify_exp got=%0d want=20", bus.expected_out);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (outs() !== '0)
      $display("FAIL rst_verify got=%h want=0", outs());
    else n_pass++;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) step(1, seq[i] * 5, 5, 0);
    n_total++;
    if (bus.locked !== 1'b1 || bus.sample_count !== CW'(3))
      $display("FAIL pre_rst_lock lk=%b sc=%0d want 1/3",
               bus.locked, bus.sample_count);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (outs() !== '0)
      $display("FAIL rst_locked got=%h want=0", outs());
    else n_pass++;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) step(1, seq[i] * 4, 4, 0);
    step(1, 0, 4, 1);
    n_total++;
    if (bus.err_pulse !== 1'b1 || bus.err_count !== CW'(0) ||
        bus.sample_count !== CW'(0) || bus.locked !== 1'b1)
      $display("FAIL clear_err pulse=%b ec=%0d sc=%0d lk=%b want 1/0/0/1",
               bus.err_pulse, bus.err_count, bus.sample_count, bus.locked);
    else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) step(1, seq[i], 1, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, seq[m_p] ^ 8'h80, 1, 0);
      step(1, seq[m_p], 1, 0);
    end
    n_total++;
    if (bus.err_count !== CW'(MAXC) || bus.sample_count !== CW'(MAXC) ||
        bus.locked !== 1'b1)
      $display("FAIL sat ec=%0d sc=%0d lk=%b want %0d/%0d/1",
               bus.err_count, bus.sample_count, bus.locked, MAXC, MAXC);
    else n_pass++;
    step(1, seq[m_p] ^ 8'h80, 1, 0);
    n_total++;
    if (bus.err_count !== CW'(MAXC) || bus.err_pulse !== 1'b1)
      $display("FAIL sat_hold ec=%0d pulse=%b want %0d/1",
               bus.err_count, bus.err_pulse, MAXC);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      int v;
      v = seq[m_p] * 15;
      step(1, v, 15, 0);
      n_total++;
      if (bus.err_pulse !== 1'b0 || bus.expected_out !== 8'(v))
        $display("FAIL gain15 i=%0d pulse=%b exp=%0d want 0/%0d",
                 i, bus.err_pulse, bus.expected_out, v);
      else n_pass++;
    end
    n_total++;
    if (bus.locked !== 1'b1)
      $display("FAIL gain15_lock got=%b want=1", bus.locked);
    else n_pass++;
  endtask

  task automatic test_random();
    int gidx, gg, n;
    bit v, c;
    logic [2*CW+9:0] want;
    do_reset();
    gidx = $urandom_range(0, 14);
    gg   = $urandom_range(1, 15);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) gg = $urandom_range(0, 15);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 29) == 0);
      n = seq[gidx] * gg;
      if ($urandom_range(0, 9) == 0) n = $urandom_range(0, 255);
      if (v) gidx = (gidx + 1) % 15;
      step(v, n, gg, c);
      want = {m_mode == 2, m_err[0], 8'(m_exp), CW'(m_ec), CW'(m_sc)};
      n_total++;
      if (outs() !== want)
        $display("FAIL random i=%0d got=%h want=%h", i, outs(), want);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.noise_in     = 8'd0;
    bus.noise_gain   = 4'd0;
    bus.clear        = 1'b0;
    model_reset();
    test_reset();
    test_lock();
    test_flywheel();
    test_loss_relock();
    test_search_reject();
    test_async_reset();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
